// File: rtl/hazard_stall_unit.sv
// Hazard and stall unit for a 5-stage pipeline that also has a multi-cycle mul/div unit.
// It resolves three kinds of hazard:
//   - load-use hazards,
//   - read-after-write hazards against in-flight mul/div results, tracked by a scoreboard,
//   - structural hazards on the single mul/div unit.
// A taken branch/jump resolved in Execute overrides every stall, because the
// instruction in Decode is on the wrong path.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rdD,
  input  logic       RegWriteD,
  input  logic       MulDivD,
  input  logic [4:0] rdE,
  input  logic       ResultSrcE0,
  input  logic       MulDivStartE,
  input  logic       PCSrcE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       md_busy,
  output logic       md_wb_valid,
  output logic [4:0] md_wb_rd,
  output logic       md_err
);

  // The countdown starts at MD_LATENCY-1, so write-back lands MD_LATENCY cycles after the start.
  localparam logic [4:0] CNT_LOAD = 5'(MD_LATENCY - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic [4:0]  r_md_rd;
  logic [31:0] r_pend;
  logic [31:0] w_pend_next;
  logic        r_err;

  logic        w_start_ok;
  logic        w_start_err;
  logic        w_done;
  logic        w_lw_stall;
  logic        w_sb_stall;
  logic        w_start_stall;
  logic        w_struct_stall;
  logic        w_stall;

  // A start is accepted only in IDLE. A start that arrives while BUSY is flagged as an error and dropped.
  assign w_start_ok  = MulDivStartE & (r_state == S_IDLE);
  assign w_start_err = MulDivStartE & (r_state == S_BUSY);
  assign w_done      = (r_state == S_BUSY) & (r_cnt == 5'd0);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (MulDivStartE) begin
          w_state_next = S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 5'd0) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs; the write-back fields are decoded from registered state only
  always_comb begin
    md_busy     = 1'b0;
    md_wb_valid = 1'b0;
    md_wb_rd    = 5'd0;
    case (r_state)
      S_IDLE: begin
        md_busy     = 1'b0;
        md_wb_valid = 1'b0;
        md_wb_rd    = 5'd0;
      end
      S_BUSY: begin
        md_busy = 1'b1;
        if (r_cnt == 5'd0) begin
          md_wb_valid = 1'b1;
          md_wb_rd    = r_md_rd;
        end else begin
          md_wb_valid = 1'b0;
          md_wb_rd    = 5'd0;
        end
      end
      default: begin
        md_busy     = 1'b0;
        md_wb_valid = 1'b0;
        md_wb_rd    = 5'd0;
      end
    endcase
  end

  // Latency countdown: load it on an accepted start, then decrement while BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 5'd0;
    end else if (w_start_ok) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == S_BUSY) && (r_cnt != 5'd0)) begin
      r_cnt <= r_cnt - 5'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Capture the destination register of the accepted mul/div
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_md_rd <= 5'd0;
    end else if (w_start_ok) begin
      r_md_rd <= rdE;
    end else begin
      r_md_rd <= r_md_rd;
    end
  end

  // Scoreboard update: set the bit on an accepted start, clear it on write-back; x0 is never pending
  always_comb begin
    w_pend_next = r_pend;
    if (w_done) begin
      w_pend_next[r_md_rd] = 1'b0;
    end else if (w_start_ok && (rdE != 5'd0)) begin
      w_pend_next[rdE] = 1'b1;
    end else begin
      w_pend_next = r_pend;
    end
    w_pend_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 32'd0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // Sticky protocol-error flag; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_err) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign md_err = r_err;

  // Hazard detection, and a taken branch overriding every stall term
  always_comb begin
    w_lw_stall     = ResultSrcE0 & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
    w_sb_stall     = r_pend[rs1D] | r_pend[rs2D] | (RegWriteD & r_pend[rdD]);
    w_start_stall  = MulDivStartE & (rdE != 5'd0) &
                     ((rdE == rs1D) | (rdE == rs2D) | (RegWriteD & (rdE == rdD)));
    w_struct_stall = MulDivD & (md_busy | MulDivStartE);
    w_stall        = (w_lw_stall | w_sb_stall | w_start_stall | w_struct_stall) & ~PCSrcE;
    StallF         = w_stall;
    StallD         = w_stall;
    FlushE         = w_stall | PCSrcE;
    FlushD         = PCSrcE;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit with MD_LATENCY = 8.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rdD, rdE;
  logic       RegWriteD, MulDivD, ResultSrcE0, MulDivStartE, PCSrcE;
  logic       StallF, StallD, FlushD, FlushE;
  logic       md_busy, md_wb_valid, md_err;
  logic [4:0] md_wb_rd;

  int passed = 0;
  int total  = 0;

  hazard_stall_unit #(.MD_LATENCY(8)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .RegWriteD(RegWriteD), .MulDivD(MulDivD),
    .rdE(rdE), .ResultSrcE0(ResultSrcE0), .MulDivStartE(MulDivStartE), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .md_busy(md_busy), .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd), .md_err(md_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rdd;
    logic       rw, mdd;
    logic [4:0] rde;
    logic       ld, st, pc;
    logic [3:0] exp;  // {StallF, StallD, FlushD, FlushE}
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic md, input logic [4:0] re,
                       input logic ld, input logic st, input logic pc);
    rs1D = r1; rs2D = r2; rdD = rd; RegWriteD = rw; MulDivD = md;
    rdE = re; ResultSrcE0 = ld; MulDivStartE = st; PCSrcE = pc;
  endtask

  function automatic logic [3:0] ctl();
    return {StallF, StallD, FlushD, FlushE};
  endfunction

  function automatic logic [7:0] mdv();
    return {StallF, md_busy, md_wb_valid, md_wb_rd};
  endfunction

  initial begin
    // Combinational vectors, all applied with pend = 0 and the unit idle
    vecs[0]  = '{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1101}; // load-use on rs1
    vecs[1]  = '{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000}; // load to x0, rs1=5
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000}; // load x0 vs rs1=x0
    vecs[3]  = '{5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1101}; // load-use on rs2
    vecs[4]  = '{5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000}; // load vs rdD only
    vecs[5]  = '{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0000}; // not a load
    vecs[6]  = '{5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 4'b1101}; // start WAW on rdD
    vecs[7]  = '{5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 4'b0000}; // rdD without RegWrite
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000}; // start to x0
    vecs[9]  = '{5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 4'b1101}; // structural on start
    vecs[10] = '{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 4'b0011}; // branch beats load-use
    vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0011}; // branch alone
    vecs[12] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 4'b0000}; // mul/div in D, unit idle

    // Reset state, with the stall equations still live during reset
    rst = 1'b1;
    drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    #2;
    check("reset_md", {27'd0, md_busy, md_wb_valid, md_err, md_wb_rd[1:0]}, 32'd0);
    check("reset_wbrd", {27'd0, md_wb_rd}, 32'd0);
    check("reset_ctl_eq", {28'd0, ctl()}, 32'hD);
    @(negedge clk);
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Apply the vector table; inputs return to zero before each rising edge
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rdd, vecs[i].rw, vecs[i].mdd,
            vecs[i].rde, vecs[i].ld, vecs[i].st, vecs[i].pc);
      #1;
      check($sformatf("vec%0d", i), {28'd0, ctl()}, {28'd0, vecs[i].exp});
      #1;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    check("idle_after_vecs", {31'd0, md_busy}, 32'd0);

    // Mul/div chain: start rd=7 in cycle 0 while Decode reads x7 as rs2
    @(negedge clk);
    drive(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
    #1;
    check("chain_c0", {24'd0, mdv()}, {24'd0, 8'b1000_0000});
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      drive(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("chain_c%0d", c), {24'd0, mdv()},
            {24'd0, (c <= 8) ? 1'b1 : 1'b0, (c <= 8) ? 1'b1 : 1'b0,
             (c == 8) ? 1'b1 : 1'b0, (c == 8) ? 5'd7 : 5'd0});
    end

    // Structural hazard: a mul/div sits in Decode during the start and the whole busy period
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (c == 0) ? 5'd4 : 5'd0, 1'b0, (c == 0) ? 1'b1 : 1'b0, 1'b0);
      #1;
      check($sformatf("struct_c%0d", c), {28'd0, ctl()}, {28'd0, (c <= 8) ? 4'b1101 : 4'b0000});
    end

    // Branch priority and protocol error: start rd=10 in cycle 0, error start in cycle 3
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 2) begin
        drive(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
      end else if (c == 3) begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b0, 1'b1, 1'b0);
      end else if (c == 9) begin
        drive(5'd10, 5'd11, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      end else begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      end
      #1;
      if (c == 2) begin
        check("branch_prio", {28'd0, ctl()}, 32'h3);
      end else begin
        check($sformatf("err_c%0d", c), {23'd0, md_err, mdv()},
              {23'd0, (c >= 4) ? 1'b1 : 1'b0, 1'b0, (c <= 8) ? 1'b1 : 1'b0,
               (c == 8) ? 1'b1 : 1'b0, (c == 8) ? 5'd10 : 5'd0});
      end
    end

    // Reset in cycle 5 of a new operation abandons it and clears the error and scoreboard
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0, 1'b1, 1'b0);
      end else begin
        drive(5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      end
      if (c == 5) begin
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      #1;
      if (c >= 1) begin
        check($sformatf("rst_c%0d", c), {23'd0, md_err, mdv()},
              {23'd0, (c < 5) ? 1'b1 : 1'b0, (c < 5) ? 1'b1 : 1'b0,
               (c < 5) ? 1'b1 : 1'b0, 1'b0, 5'd0});
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter: MD_LATENCY, default 8, sets the mul/div latency in cycles (legal range 2..32).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 rs1D, rs2D  in  5 each  source register fields of the instruction in Decode.
REQ-005 rdD  in  5  destination register of the instruction in Decode.
REQ-006 RegWriteD  in  1  Decode instruction writes rdD.
REQ-007 MulDivD  in  1  Decode instruction is a mul/div.
REQ-008 rdE  in  5  destination register of the instruction in Execute.
REQ-009 ResultSrcE0  in  1  Execute instruction is a load.
REQ-010 MulDivStartE  in  1  Execute instruction is a mul/div and starts this cycle.
REQ-011 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-012 StallF, StallD  out  1 each  hold the PC register and the IF/ID register.
REQ-013 FlushD, FlushE  out  1 each  bubble the IF/ID and ID/EX registers.
REQ-014 md_busy  out  1  mul/div unit occupied.
REQ-015 md_wb_valid  out  1  mul/div result write-back pulse.
REQ-016 md_wb_rd  out  5  destination register for the mul/div write-back.
REQ-017 md_err  out  1  sticky protocol-error flag.

Function
REQ-018 Scoreboard: pend[31:0] register, one bit per architectural register; pend[0] SHALL always read 0.
REQ-019 FSM states: IDLE and BUSY. md_busy SHALL be 1 exactly when the state is BUSY.
REQ-020 In IDLE, MulDivStartE=1 SHALL cause the following transitions at the clock edge:
  - state <= BUSY
  - cnt <= MD_LATENCY-1
  - md_rd <= rdE
  - pend[rdE] <= 1 (only if rdE != 0)
REQ-021 In BUSY with cnt != 0, cnt SHALL decrement by 1 each cycle.
REQ-022 In BUSY with cnt == 0:
  - md_wb_valid SHALL be 1 and md_wb_rd SHALL equal md_rd, for exactly this cycle.
  - At the edge, pend[md_rd] SHALL clear and the state SHALL return to IDLE.
REQ-023 Latency: a start in cycle t SHALL produce md_wb_valid in cycle t+MD_LATENCY.
REQ-024 md_wb_valid and md_wb_rd SHALL be decoded from registers only; md_wb_rd SHALL be 0 when md_wb_valid=0.
REQ-025 MulDivStartE=1 while in BUSY is a protocol error:
  - The start SHALL be ignored; FSM, cnt and pend are unchanged.
  - md_err SHALL set and stay set until rst.
REQ-026 lwStall = ResultSrcE0 & (rdE != 0) & (rdE == rs1D | rdE == rs2D).
REQ-027 sbStall = pend[rs1D] | pend[rs2D] | (RegWriteD & pend[rdD]).
REQ-028 startStall = MulDivStartE & (rdE != 0) & (rdE == rs1D | rdE == rs2D | (RegWriteD & rdE == rdD)).
REQ-029 structStall = MulDivD & (md_busy | MulDivStartE).
REQ-030 stall = (lwStall | sbStall | startStall | structStall) & ~PCSrcE.
REQ-031 Output equations:
  - StallF = StallD = stall
  - FlushE = stall | PCSrcE
  - FlushD = PCSrcE
REQ-032 PCSrcE SHALL override all stall terms in the same cycle, since the Decode instruction is on the wrong path.
REQ-033 A register whose pend bit clears at an edge SHALL stop stalling Decode from the next cycle.
REQ-034 Stall, flush, md_busy, cnt and md_err logic SHALL be identical for every MD_LATENCY value in range.

Reset
REQ-035 While rst=1, the following SHALL hold asynchronously:
  - state = IDLE, cnt = 0, md_rd = 0, pend = 0
  - md_err = 0, md_busy = 0, md_wb_valid = 0, md_wb_rd = 0
REQ-036 While rst=1, StallF, StallD, FlushD and FlushE SHALL follow their equations using the reset state.
REQ-037 Reset mid-operation SHALL abandon the in-flight mul/div: no md_wb_valid is produced and all pend bits are cleared.

Verification
REQ-038 Load-use: ResultSrcE0=1, rdE=5, rs1D=5, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0. Same with rdE=0 -> all outputs 0.
REQ-039 Mul/div chain, MD_LATENCY=8:
  - Start with rdE=7 at cycle 0 -> md_busy=1 in cycles 1..8.
  - md_wb_valid=1 and md_wb_rd=7 in cycle 8 only.
  - rs2D=7 in Decode -> stall in cycles 0..8, released in cycle 9.
REQ-040 Structural hazard: MulDivD=1 while MulDivStartE=1, then while md_busy=1 -> stall=1 in every one of those cycles, released in the cycle after md_wb_valid.
REQ-041 Branch priority: PCSrcE=1 together with lwStall and sbStall conditions -> StallF=StallD=0, FlushD=FlushE=1.
REQ-042 Error and reset:
  - Second MulDivStartE in cycle 3 of a busy period -> md_err=1, cnt unaffected, write-back still in cycle 8.
  - rst pulse in cycle 5 of a new operation -> all outputs 0, pend=0, no md_wb_valid afterwards.
